// File: rtl/alu_logic_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake and ZERO/ONES flags.
// Both stages advance together; a stalled consumer freezes the whole pipe.
module alu_logic_pipe #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic [WIDTH-1:0] OUT,
  output logic             ZERO,
  output logic [CW-1:0]    ONES,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_s_r;
  logic             s1_valid_r;
  logic [WIDTH-1:0] out_r;
  logic             zero_r;
  logic [CW-1:0]    ones_r;
  logic             out_valid_r;

  logic             adv_s;
  logic [WIDTH-1:0] res_s;
  logic             zero_s;
  logic [CW-1:0]    ones_s;

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       s
  );
    logic [WIDTH-1:0] r;
    case (s)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~a;
      3'b100:  r = ~(a & b);
      3'b101:  r = ~(a | b);
      3'b110:  r = ~(a ^ b);
      3'b111:  r = b;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(CW-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  assign adv_s    = ~out_valid_r | OUT_READY;
  assign IN_READY = adv_s;

  // Result and flags derived from the stage-1 operands
  always_comb begin
    res_s  = logic_op(s1_a_r, s1_b_r, s1_s_r);
    zero_s = (res_s == {WIDTH{1'b0}});
    ones_s = popcount(res_s);
  end

  // Stage 1: operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_s_r     <= 3'b000;
      s1_valid_r <= 1'b0;
    end else if (adv_s) begin
      s1_a_r     <= A;
      s1_b_r     <= B;
      s1_s_r     <= S;
      s1_valid_r <= IN_VALID;
    end
  end

  // Stage 2: registered result, flags and output valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r       <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      ones_r      <= {CW{1'b0}};
      out_valid_r <= 1'b0;
    end else if (adv_s) begin
      out_r       <= res_s;
      zero_r      <= zero_s;
      ones_r      <= ones_s;
      out_valid_r <= s1_valid_r;
    end
  end

  assign OUT       = out_r;
  assign ZERO      = zero_r;
  assign ONES      = ones_r;
  assign OUT_VALID = out_valid_r;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Scoreboard bench for alu_logic_pipe: directed vectors pushed at accept, checked by a monitor.
module tb_alu_logic_pipe;

  typedef struct packed {
    logic [7:0] out;
    logic       zero;
    logic [3:0] ones;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [7:0]  a, b, out;
  logic [2:0]  s;
  logic [3:0]  ones;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16;
  logic [15:0] a16, b16, out16;
  logic [2:0]  s16;
  logic [4:0]  ones16;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_logic_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .S(s),
    .OUT(out), .ZERO(zero), .ONES(ones),
    .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  alu_logic_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .IN_VALID(in_valid16), .IN_READY(in_ready16),
    .A(a16), .B(b16), .S(s16),
    .OUT(out16), .ZERO(zero16), .ONES(ones16),
    .OUT_VALID(out_valid16), .OUT_READY(out_ready16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] o, input logic [3:0] n);
    exp_t e;
    e.out  = o;
    e.zero = (o == 8'h00);
    e.ones = n;
    return e;
  endfunction

  // Independent reference for the randomised vectors
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] sv);
    logic [7:0] r;
    case (sv)
      3'd0:    r = av & bv;
      3'd1:    r = av | bv;
      3'd2:    r = av ^ bv;
      3'd3:    r = ~av;
      3'd4:    r = ~(av & bv);
      3'd5:    r = ~(av | bv);
      3'd6:    r = ~(av ^ bv);
      default: r = bv;
    endcase
    return mk(r, 4'($countones(r)));
  endfunction

  // Monitor: every presented result must match the scoreboard head; pop on transfer
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none", out);
      end else begin
        chk("out",  {24'd0, out},  {24'd0, exp_q[0].out});
        chk("zero", {31'd0, zero}, {31'd0, exp_q[0].zero});
        chk("ones", {28'd0, ones}, {28'd0, exp_q[0].ones});
        if (out_ready) exp_q.delete(0);
      end
    end
  end

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] sv, input exp_t e);
    in_valid = 1'b1;
    a = av;
    b = bv;
    s = sv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: got in_ready=0 expected 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_latency(input string name);
    int n;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n, 32'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    logic [7:0] av, bv;
    logic [2:0] sv;

    rst = 1'b1;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; s = 3'd0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; s16 = 3'd0; out_ready16 = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out",       {24'd0, out},       32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd1);
    chk("rst_ones",      {28'd0, ones},      32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Legacy ops, each with a 2-edge latency
    send(8'd10, 8'd10, 3'd0, mk(8'd10,  4'd2)); check_latency("lat_and");
    send(8'd20, 8'd10, 3'd1, mk(8'd30,  4'd4)); check_latency("lat_or");
    send(8'd3,  8'd5,  3'd2, mk(8'd6,   4'd2)); check_latency("lat_xor");
    send(8'd0,  8'h5A, 3'd3, mk(8'd255, 4'd8)); check_latency("lat_not");
    drain();

    // Extended ops
    send(8'hF0, 8'h3C, 3'd4, mk(8'hCF, 4'd6));
    send(8'hF0, 8'h3C, 3'd5, mk(8'h03, 4'd2));
    send(8'hF0, 8'h3C, 3'd6, mk(8'h33, 4'd4));
    send(8'hF0, 8'h3C, 3'd7, mk(8'h3C, 4'd4));
    drain();

    // Back-to-back at full rate
    start = cyc;
    for (int i = 0; i < 16; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      sv = 3'($urandom_range(0, 7));
      send(av, bv, sv, model(av, bv, sv));
    end
    chk("throughput_cycles", cyc - start, 32'd16);
    send(8'hAA, 8'h55, 3'd0, mk(8'h00, 4'd0));
    drain();

    // Backpressure with a full pipe
    send(8'h12, 8'h34, 3'd1, mk(8'h36, 4'd4));
    send(8'h0F, 8'hFF, 3'd0, mk(8'h0F, 4'd4));
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'hC3; b = 8'h81; s = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'hC3, 8'h81, 3'd2, mk(8'h42, 4'd2));
    drain();

    // Async reset in the middle of a stall with two ops in flight
    send(8'h01, 8'h02, 3'd1, mk(8'h03, 4'd2));
    send(8'h07, 8'h0E, 3'd0, mk(8'h06, 4'd2));
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out",       {24'd0, out},       32'd0);
    chk("midrst_zero",      {31'd0, zero},      32'd1);
    chk("midrst_ones",      {28'd0, ones},      32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_no_output", {31'd0, out_valid}, 32'd0);
    send(8'h80, 8'h01, 3'd5, mk(8'h7E, 4'd6));
    drain();

    // 16-bit instance
    in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; s16 = 3'd1;
    @(negedge clk);
    chk("w16_in_ready", {31'd0, in_ready16}, 32'd1);
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    for (int i = 0; i < 10 && !out_valid16; i++) begin
      @(posedge clk);
      #1;
    end
    chk("w16_out_valid", {31'd0, out_valid16}, 32'd1);
    chk("w16_out",       {16'd0, out16},       32'h0000FFFF);
    chk("w16_ones",      {27'd0, ones16},      32'd16);
    chk("w16_zero",      {31'd0, zero16},      32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
